reg_dump: RTL and testbench
===========================

# reg_dump

Debug register reader that sits beside `regfile` on its FPGA read interface. On a start pulse it walks `reg_addr` from 0 to 15 and captures each 32-bit `reg_output` word (R15 returns the zero-extended 7-bit PC). It then serializes each word MSB-first as four bytes on a valid/ready byte stream that feeds the board UART transmitter or a display driver. It lets a host dump the architectural register state without halting the datapath.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  request a dump; sampled only in IDLE
- `reg_addr`  out  4  register select, driven to `regfile` `reg_addr`
- `reg_output`  in  32  combinational read data from `regfile`
- `status_in`  in  32  `regfile` `status_out`; used only with `REG_DUMP_STATUS_EN`
- `byte_data`  out  8  stream byte
- `byte_valid`  out  1  `byte_data` holds a valid byte
- `byte_ready`  in  1  sink accepts the byte in the current cycle
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when the dump completes

## Operation
- States:
  - IDLE: `reg_addr`=0, `byte_valid`=0. On `start`=1, clear the word index and go to LOAD.
  - LOAD: `reg_addr` = word index (capped at 15). At the clock edge, capture `reg_output` into a 32-bit shift register, or `status_in` for word 16. Clear the byte counter and go to SEND.
  - SEND: `byte_valid`=1, `byte_data` = shift[31:24]. On `byte_valid && byte_ready`:
    - Shift left 8 and increment the 2-bit byte counter.
    - After byte 3: go to DONE if this is the last word. Otherwise increment the word index and go to LOAD.
  - DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Word order: R0..R15, then the status register if it is compiled in. Byte order within a word: [31:24], [23:16], [15:8], [7:0].
- The 5-bit word index runs 0..15, or 0..16 with status. It never wraps during a dump.
- `start` is ignored in LOAD, SEND and DONE. A `start` asserted in DONE is also ignored, so a new dump needs a `start` sampled in IDLE.
- `byte_data` and `byte_valid` hold steady while `byte_valid && !byte_ready`. `byte_data` is not required to hold a particular value while `byte_valid`=0.
- Captured words are snapshots taken in LOAD. Register writes made after capture do not alter bytes that are already latched.
- Reset (`rst_n`=0 at an edge) from any state, including mid-word: state becomes IDLE. A partially sent word is abandoned, and no `done` pulse is produced.

## Timing
- Reset values: `reg_addr`=0, `byte_data`=0x00, `byte_valid`=0, `busy`=0, `done`=0; state IDLE, word index 0, byte counter 0.
- Cycle 0 is the edge at which `start` is sampled. With `byte_ready` held at 1 and no status word:
  - Cycle 1: LOAD for word 0.
  - Cycles 2–5: SEND for word 0.
  - Word k: LOAD in cycle 1+5k, SEND in cycles 2+5k through 5+5k.
  - Last byte in cycle 80; `done` in cycle 81; IDLE from cycle 82.
- With `REG_DUMP_STATUS_EN` and `byte_ready` held at 1: last byte in cycle 85, `done` in cycle 86.
- Each cycle with `byte_ready`=0 in SEND adds one cycle to the dump.
- `busy` goes high in cycle 1 and stays high through the DONE cycle.
- `reg_output` is read combinationally in the same cycle that `reg_addr` is driven. No extra wait state is used.

## Configuration
- `REG_DUMP_STATUS_EN` defined:
  - After R15, send a 17th word taken from `status_in`; `reg_addr` stays at 15 during that LOAD.
  - The dump is 68 bytes.
- Not defined:
  - `status_in` is unused.
  - The dump is 16 words, 64 bytes; DONE follows R15 directly.

## Test plan
- Preload R0..R14 = 0x1000_0000+n and PC = 0x55. Pulse `start` with `byte_ready`=1. Required:
  - First bytes 10 00 00 00, then 10 00 00 01, and so on.
  - R15 sent as 00 00 00 55.
  - `done` in cycle 81.
  - 64 bytes total.
- Toggle `byte_ready` randomly at 50%. Required:
  - Byte sequence identical to the preceding case.
  - `byte_data` and `byte_valid` stable during every stall.
  - No byte lost or duplicated.
- Pulse `start` again in cycles 3 and 40 of a dump. Required: both pulses ignored, exactly 64 bytes, one `done` pulse.
- Drive `rst_n`=0 for one cycle after byte 2 of R5. Required:
  - `byte_valid`=0, `busy`=0 and `reg_addr`=0 the next cycle.
  - A new `start` begins again at R0 byte 0.
- Build with `REG_DUMP_STATUS_EN` and `status_in`=0xA000_0000. Required: 68 bytes, last four A0 00 00 00, `done` in cycle 86.
- Write R3 = 0xDEAD_BEEF through `regfile` while R3 is being sent. Required: the bytes already latched for R3 are unchanged.

Source files
------------

// File: rtl/reg_dump.sv
// -----------------------------------------------------------------------------
// reg_dump
// Debug register reader placed beside the regfile read port. A start pulse
// sampled in IDLE walks reg_addr over R0..R15 and captures each 32-bit word
// into a shift register. Each word is then streamed MSB-first as four bytes
// on a valid/ready byte interface.
//
// Optional feature macro: REG_DUMP_STATUS_EN
//   When defined, a 17th word taken from status_in is sent after R15.
//   reg_addr stays at 15 while that word is loaded.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   start       dump request, honoured only in IDLE
//   reg_addr    register select to regfile
//   reg_output  combinational regfile read data
//   status_in   regfile status word (used only with REG_DUMP_STATUS_EN)
//   byte_data   stream byte
//   byte_valid  byte_data holds a valid byte
//   byte_ready  sink accepts the byte this cycle
//   busy        high in every state except IDLE
//   done        one-cycle pulse when the dump completes
// -----------------------------------------------------------------------------
module reg_dump (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [3:0]  reg_addr,
   input  logic [31:0] reg_output,
   input  logic [31:0] status_in,
   output logic [7:0]  byte_data,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } state_t;

`ifdef REG_DUMP_STATUS_EN
   localparam logic [4:0] LAST_WORD = 5'd16;
`else
   localparam logic [4:0] LAST_WORD = 5'd15;
   // status word is not part of the dump in this build
   logic unused_status_s;
   assign unused_status_s = ^status_in;
`endif

   state_t      state_r;
   logic [4:0]  word_idx_r;
   logic [1:0]  byte_cnt_r;
   logic [31:0] shift_r;
   logic [3:0]  reg_addr_r;
   logic        byte_valid_r;
   logic        busy_r;
   logic        done_r;

   // Word 16 (status) has no regfile address; hold the select at R15.
   function automatic logic [3:0] cap_addr(input logic [4:0] idx);
      if (idx > 5'd15) begin
         return 4'd15;
      end else begin
         return idx[3:0];
      end
   endfunction

   // Word source selection: status word follows R15 when compiled in.
   function automatic logic [31:0] pick_word(input logic [4:0] idx,
                                             input logic [31:0] rd,
                                             input logic [31:0] st);
`ifdef REG_DUMP_STATUS_EN
      if (idx == 5'd16) begin
         return st;
      end else begin
         return rd;
      end
`else
      // st is only meaningful with the status word compiled in
      return rd | (st & 32'h0000_0000);
`endif
   endfunction

   // Dump FSM with all outputs registered alongside the state transitions
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         word_idx_r   <= 5'd0;
         byte_cnt_r   <= 2'd0;
         shift_r      <= 32'h0000_0000;
         reg_addr_r   <= 4'd0;
         byte_valid_r <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r       <= 1'b0;
               byte_valid_r <= 1'b0;
               reg_addr_r   <= 4'd0;
               if (start) begin
                  word_idx_r <= 5'd0;
                  busy_r     <= 1'b1;
                  state_r    <= ST_LOAD;
               end else begin
                  busy_r     <= 1'b0;
               end
            end

            ST_LOAD: begin
               // reg_addr_r already selects this word; regfile read is combinational
               shift_r      <= pick_word(word_idx_r, reg_output, status_in);
               byte_cnt_r   <= 2'd0;
               byte_valid_r <= 1'b1;
               state_r      <= ST_SEND;
            end

            ST_SEND: begin
               if (byte_ready) begin
                  shift_r    <= {shift_r[23:0], 8'h00};
                  byte_cnt_r <= byte_cnt_r + 2'd1;
                  if (byte_cnt_r == 2'd3) begin
                     byte_valid_r <= 1'b0;
                     if (word_idx_r == LAST_WORD) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                     end else begin
                        word_idx_r <= word_idx_r + 5'd1;
                        reg_addr_r <= cap_addr(word_idx_r + 5'd1);
                        state_r    <= ST_LOAD;
                     end
                  end else begin
                     byte_valid_r <= 1'b1;
                  end
               end else begin
                  // stall: byte and valid hold
                  byte_valid_r <= 1'b1;
               end
            end

            ST_DONE: begin
               // start is deliberately not sampled here
               done_r     <= 1'b0;
               busy_r     <= 1'b0;
               reg_addr_r <= 4'd0;
               state_r    <= ST_IDLE;
            end

            default: begin
               state_r      <= ST_IDLE;
               byte_valid_r <= 1'b0;
               busy_r       <= 1'b0;
               done_r       <= 1'b0;
               reg_addr_r   <= 4'd0;
            end
         endcase
      end
   end

   assign reg_addr   = reg_addr_r;
   assign byte_data  = shift_r[31:24];
   assign byte_valid = byte_valid_r;
   assign busy       = busy_r;
   assign done       = done_r;

endmodule

// File: tb/tb_reg_dump.sv
// -----------------------------------------------------------------------------
// tb_reg_dump
// Self-checking bench for reg_dump. A small regfile model answers reg_addr
// combinationally; the expected byte stream is built from the register
// contents at dump start, and a negedge monitor collects accepted bytes,
// done pulses and stall stability.
// -----------------------------------------------------------------------------
module tb_reg_dump;

`ifdef REG_DUMP_STATUS_EN
   localparam int NUM_WORDS = 17;
   localparam int DONE_CYC  = 86;
`else
   localparam int NUM_WORDS = 16;
   localparam int DONE_CYC  = 81;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  reg_addr;
   logic [31:0] reg_output;
   logic [31:0] status_in;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        byte_ready;
   logic        busy;
   logic        done;

   int total = 0;
   int bad   = 0;

   logic [31:0] regs [0:15];
   logic [6:0]  pc;

   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];
   bit         mon_en = 1'b0;
   int         rel = -10;
   int         done_cnt = 0;
   int         done_cyc = 0;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always #5 clk = ~clk;

   reg_dump dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .reg_addr   (reg_addr),
      .reg_output (reg_output),
      .status_in  (status_in),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .busy       (busy),
      .done       (done)
   );

   // regfile read model: R15 returns the zero-extended PC
   always_comb begin
      if (reg_addr == 4'd15) reg_output = {25'd0, pc};
      else                   reg_output = regs[reg_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // expected stream: every word MSB byte first, in dump order
   function automatic void build_exp();
      logic [31:0] w;
      exp_q.delete();
      for (int k = 0; k < NUM_WORDS; k++) begin
         if (k < 15)       w = regs[k];
         else if (k == 15) w = {25'd0, pc};
         else              w = status_in;
         for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
      end
   endfunction

   // monitor: accepted bytes, done pulses, stall stability, busy in cycle 1
   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_stall) begin
            check("stall_valid", {31'd0, byte_valid}, 32'd1);
            check("stall_data", {24'd0, byte_data}, {24'd0, prev_data});
         end
         if (byte_valid && byte_ready) got_q.push_back(byte_data);
         if (done) begin
            done_cnt++;
            done_cyc = rel + 1;
         end
         if (rel == 0) check("busy_cycle1", {31'd0, busy}, 32'd1);
         prev_stall = byte_valid && !byte_ready;
         prev_data  = byte_data;
      end
   end

   // mode 0: ready=1, 1: random ready, 2: ready=1 with stray starts,
   // 3: random ready with an R3 write while R3 is on the wire
   task automatic run_dump(input int mode, input string name);
      bit wrote = 1'b0;
      int n;
      build_exp();
      got_q.delete();
      done_cnt   = 0;
      done_cyc   = 0;
      prev_stall = 1'b0;
      rel        = -10;
      @(posedge clk); #1;
      start      = 1'b1;
      byte_ready = 1'b1;
      mon_en     = 1'b1;
      @(posedge clk);
      rel = 0;
      #1;
      start = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if (done_cnt > 0) break;
         @(posedge clk);
         rel++;
         #1;
         start = (mode == 2 && (rel == 2 || rel == 39)) ? 1'b1 : 1'b0;
         byte_ready = (mode == 1 || mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
         if (mode == 3 && !wrote && got_q.size() >= 13) begin
            regs[3] = 32'hDEAD_BEEF;
            wrote   = 1'b1;
         end
      end
      @(posedge clk); #1;
      mon_en     = 1'b0;
      start      = 1'b0;
      byte_ready = 1'b1;
      check({name, "_done_count"}, done_cnt, 32'd1);
      check({name, "_byte_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_byte%0d", name, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
      if (mode == 0 || mode == 2) check({name, "_done_cycle"}, done_cyc, DONE_CYC);
      check({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
      check({name, "_idle_valid"}, {31'd0, byte_valid}, 32'd0);
   endtask

   // reset after byte 2 of R5 has been accepted
   task automatic reset_mid_dump();
      got_q.delete();
      done_cnt   = 0;
      prev_stall = 1'b0;
      rel        = -10;
      @(posedge clk); #1;
      start      = 1'b1;
      byte_ready = 1'b1;
      mon_en     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (got_q.size() >= 23) break;
         @(posedge clk); #1;
      end
      check("rst_reached_r5", {31'd0, (got_q.size() >= 23)}, 32'd1);
      rst_n  = 1'b0;
      mon_en = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("rst_valid", {31'd0, byte_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_addr", {28'd0, reg_addr}, 32'd0);
      repeat (3) begin
         @(negedge clk);
         check("rst_no_done", {31'd0, done}, 32'd0);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      byte_ready = 1'b0;
      status_in  = 32'hA000_0000;
      pc         = 7'h55;
      for (int i = 0; i < 16; i++) regs[i] = 32'h1000_0000 + i;

      repeat (3) @(posedge clk);
      #1;
      check("reset_addr", {28'd0, reg_addr}, 32'd0);
      check("reset_data", {24'd0, byte_data}, 32'd0);
      check("reset_valid", {31'd0, byte_valid}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      rst_n = 1'b1;

      run_dump(0, "seq");
      run_dump(1, "stall");
      run_dump(2, "restart");
      reset_mid_dump();
      run_dump(0, "after_rst");
      run_dump(3, "r3_write");
      regs[3] = 32'h1000_0003;

      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      pc        = 7'($urandom);
      status_in = $urandom;
      run_dump(1, "rand_data");
      run_dump(0, "rand_seq");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
